// File: rtl/tt_out_capture_monitor_if.sv
// rtl/tt_out_capture_monitor_if.sv - capture-monitor bus: DUT observation inputs, record stream, status
interface tt_out_capture_monitor_if #(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
);
    logic                     ena;
    logic [7:0]               uo_out_i;
    logic [7:0]               uio_out_i;
    logic [7:0]               uio_oe_i;
    logic                     rec_valid;
    logic                     rec_ready;
    logic [TS_W+15:0]         rec_data;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;
    logic [DROP_W-1:0]        drop_count;
    logic                     clear;

    modport master (
        output ena, uo_out_i, uio_out_i, uio_oe_i, rec_ready, clear,
        input  rec_valid, rec_data, fifo_count, overflow, drop_count
    );

    modport slave (
        input  ena, uo_out_i, uio_out_i, uio_oe_i, rec_ready, clear,
        output rec_valid, rec_data, fifo_count, overflow, drop_count
    );
endinterface

// File: rtl/tt_out_capture_monitor.sv
// rtl/tt_out_capture_monitor.sv - logs timestamped uo/uio value changes into a FWFT FIFO
// Optional feature macro: CAPTURE_UIO_EN (capture uio_out & uio_oe; otherwise uo only)
module tt_out_capture_monitor #(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    tt_out_capture_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = TS_W + 16;

    logic [TS_W-1:0]   ts;
    logic              s1_valid;
    logic [15:0]       s1_key;
    logic [TS_W-1:0]   s1_ts;
    logic              prev_valid;
    logic [15:0]       prev_key;
    logic [RW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              ovf;
    logic [DROP_W-1:0] drops;
    logic [7:0]        uio_masked;
    logic              event_hit;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

`ifdef CAPTURE_UIO_EN
    assign uio_masked = bus.uio_out_i & bus.uio_oe_i;
`else
    logic unused_uio;
    assign unused_uio = ^{bus.uio_out_i, bus.uio_oe_i};
    assign uio_masked = 8'h00;
`endif

    assign event_hit = s1_valid && (!prev_valid || (s1_key != prev_key));
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = (count != '0) && bus.rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = event_hit && (!full || pop);
    assign drop      = event_hit && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            s1_valid   <= 1'b0;
            s1_key     <= '0;
            s1_ts      <= '0;
            prev_valid <= 1'b0;
            prev_key   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            drops      <= '0;
        end else begin
            if (bus.ena) begin
                ts       <= ts + 1'b1;
                s1_valid <= 1'b1;
                s1_key   <= {uio_masked, bus.uo_out_i};
                s1_ts    <= ts;
            end else begin
                s1_valid <= 1'b0;
            end

            // Dropping ena forgets the last value so the next enabled sample is always logged.
            if (!bus.ena) begin
                prev_valid <= 1'b0;
            end else if (s1_valid) begin
                prev_valid <= 1'b1;
                prev_key   <= s1_key;
            end

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                ovf <= 1'b1;
                if (bus.clear)
                    drops <= DROP_W'(1);
                else if (drops != '1)
                    drops <= drops + 1'b1;
            end else if (bus.clear) begin
                ovf   <= 1'b0;
                drops <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= {s1_ts, s1_key};
    end

    assign bus.rec_valid  = (count != '0);
    assign bus.rec_data   = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf;
    assign bus.drop_count = drops;
endmodule
